// File: rtl/decodificador_pwm_pkg.sv
// Shared types and constants for the PWM decoder.
package decodificador_pwm_pkg;

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    ESPERA = 2'd0,
    ALTO   = 2'd1,
    BAIXO  = 2'd2
  } estado_t;

  localparam logic [1:0] CODIGO_00 = 2'b00;
  localparam logic [1:0] CODIGO_01 = 2'b01;
  localparam logic [1:0] CODIGO_10 = 2'b10;
  localparam logic [1:0] CODIGO_11 = 2'b11;

  typedef struct packed {
    logic       valido;
    logic [1:0] codigo;
  } classe_t;

  // |a - b| in 33-bit signed arithmetic, never underflows.
  function automatic logic [CNT_W:0] dif_abs(input logic [CNT_W-1:0] a,
                                             input logic [CNT_W-1:0] b);
    logic signed [CNT_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d < 0) d = -d;
    return $unsigned(d);
  endfunction

endpackage

// File: rtl/decodificador_pwm_sincronizador_borda.sv
// Two-flop synchronizer for the PWM line plus rising/falling edge detect.
module sincronizador_borda
  import decodificador_pwm_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic entrada,
  output logic s,
  output logic sub,
  output logic desc
);

  logic meta;
  logic s_q;
  logic s_prev;

  // Synchronizer chain and one-cycle delayed copy for edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta   <= 1'b0;
      s_q    <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      meta   <= entrada;
      s_q    <= meta;
      s_prev <= s_q;
    end
  end

  // Edge strobes derived from the synchronized level.
  always_comb begin
    s    = s_q;
    sub  = s_q & ~s_prev;
    desc = ~s_q & s_prev;
  end

endmodule

// File: rtl/decodificador_pwm.sv
// PWM receiver: measures high time and period, classifies the width back
// into the 2-bit largura code, flags malformed or stuck lines.
module decodificador_pwm
  import decodificador_pwm_pkg::*;
#(
  parameter int unsigned conf_periodo = 1000000,
  parameter int unsigned largura_00   = 0,
  parameter int unsigned largura_01   = 73000,
  parameter int unsigned largura_10   = 75000,
  parameter int unsigned largura_11   = 77000,
  parameter int unsigned tolerancia   = 1000,
  parameter int unsigned timeout      = 2000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [1:0]       largura,
  output logic             pronto,
  output logic             erro,
  output logic [CNT_W-1:0] medida
);

  localparam logic [CNT_W-1:0] PER = CNT_W'(conf_periodo);
  localparam logic [CNT_W-1:0] W00 = CNT_W'(largura_00);
  localparam logic [CNT_W-1:0] W01 = CNT_W'(largura_01);
  localparam logic [CNT_W-1:0] W10 = CNT_W'(largura_10);
  localparam logic [CNT_W-1:0] W11 = CNT_W'(largura_11);
  localparam logic [CNT_W-1:0] TO  = CNT_W'(timeout);
  localparam logic [CNT_W:0]   TOL = (CNT_W+1)'(tolerancia);

  logic s;
  logic sub;
  logic desc;

  estado_t          estado, estado_d;
  logic [CNT_W-1:0] cnt_alto, cnt_alto_d;
  logic [CNT_W-1:0] cnt_per, cnt_per_d;
  logic [CNT_W-1:0] w_q, w_d;
  logic [1:0]       largura_d;
  logic [CNT_W-1:0] medida_d;
  logic             pronto_d;
  logic             erro_d;
  classe_t          classe;
  logic             periodo_ok;

  sincronizador_borda u_sinc (
    .clock   (clock),
    .reset   (reset),
    .entrada (pwm_in),
    .s       (s),
    .sub     (sub),
    .desc    (desc)
  );

  // Saturating increment: counters stop at timeout and never wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v < TO) ? v + 1'b1 : v;
  endfunction

  // First nominal width (01, 10, 11 in that order) within tolerance wins.
  function automatic classe_t classificar(input logic [CNT_W-1:0] w);
    classe_t c;
    c.valido = 1'b0;
    c.codigo = CODIGO_00;
    if (dif_abs(w, W01) <= TOL) begin
      c.valido = 1'b1;
      c.codigo = CODIGO_01;
    end else if (dif_abs(w, W10) <= TOL) begin
      c.valido = 1'b1;
      c.codigo = CODIGO_10;
    end else if (dif_abs(w, W11) <= TOL) begin
      c.valido = 1'b1;
      c.codigo = CODIGO_11;
    end
    return c;
  endfunction

  // State, counters and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado   <= ESPERA;
      cnt_alto <= '0;
      cnt_per  <= '0;
      w_q      <= '0;
      largura  <= CODIGO_00;
      medida   <= '0;
      pronto   <= 1'b0;
      erro     <= 1'b0;
    end else begin
      estado   <= estado_d;
      cnt_alto <= cnt_alto_d;
      cnt_per  <= cnt_per_d;
      w_q      <= w_d;
      largura  <= largura_d;
      medida   <= medida_d;
      pronto   <= pronto_d;
      erro     <= erro_d;
    end
  end

  // Next-state, counter and strobe logic; edges win over timeouts.
  always_comb begin
    estado_d   = estado;
    cnt_alto_d = cnt_alto;
    cnt_per_d  = cnt_per;
    w_d        = w_q;
    largura_d  = largura;
    medida_d   = medida;
    pronto_d   = 1'b0;
    erro_d     = 1'b0;
    classe     = classificar(w_q);
    periodo_ok = (dif_abs(cnt_per, PER) <= TOL);

    case (estado)
      ESPERA: begin
        if (sub) begin
          cnt_alto_d = 1;
          cnt_per_d  = 1;
          estado_d   = ALTO;
        end else if (cnt_per == TO && !s) begin
          largura_d = CODIGO_00;
          medida_d  = W00;
          pronto_d  = 1'b1;
          cnt_per_d = '0;
        end else begin
          cnt_per_d = sat_inc(cnt_per);
        end
      end

      ALTO: begin
        if (desc) begin
          w_d       = cnt_alto;
          cnt_per_d = sat_inc(cnt_per);
          estado_d  = BAIXO;
        end else if (cnt_alto == TO) begin
          erro_d     = 1'b1;
          cnt_alto_d = '0;
          cnt_per_d  = '0;
          estado_d   = ESPERA;
        end else begin
          cnt_alto_d = sat_inc(cnt_alto);
          cnt_per_d  = sat_inc(cnt_per);
        end
      end

      BAIXO: begin
        if (sub) begin
          // cnt_per here is the full period; the new one starts this cycle
          // so back-to-back periods lose no cycle.
          if (!periodo_ok) begin
            erro_d = 1'b1;
          end else if (classe.valido) begin
            largura_d = classe.codigo;
            medida_d  = w_q;
            pronto_d  = 1'b1;
          end else begin
            erro_d = 1'b1;
          end
          cnt_alto_d = 1;
          cnt_per_d  = 1;
          estado_d   = ALTO;
        end else if (cnt_per == TO) begin
          largura_d  = CODIGO_00;
          medida_d   = W00;
          pronto_d   = 1'b1;
          cnt_alto_d = '0;
          cnt_per_d  = '0;
          estado_d   = ESPERA;
        end else begin
          cnt_per_d = sat_inc(cnt_per);
        end
      end

      default: begin
        estado_d   = ESPERA;
        cnt_alto_d = '0;
        cnt_per_d  = '0;
      end
    endcase
  end

endmodule
